// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: streams a WIDTH-bit operand pair LSB-first through an
// external 1-bit full adder, recirculating the carry, and reports the sum with a done pulse.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_sh_reg, sum_sh_next;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    assign sum_sh_next = (sum_sh_reg >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    assign sum_out  = sum_reg;
    assign cout_out = cout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_cin     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                fa_a   = a_sh_reg[0];
                fa_b   = b_sh_reg[0];
                fa_cin = carry_reg;
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            a_sh_reg  <= a_in;
            b_sh_reg  <= b_in;
            carry_reg <= cin_in;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_sh_reg <= sum_sh_next;
            carry_reg  <= fa_carry;
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            cnt_reg    <= cnt_reg + CW'(1);
            // Result registers only move on the final RUN edge, so they hold between operations.
            if (cnt_reg == LAST) begin
                sum_reg  <= sum_sh_next;
                cout_reg <= fa_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: 8-bit and 1-bit instances, each wired to a
// behavioural full adder, checked against table vectors and an arithmetic model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       fa_a8, fa_b8, fa_cin8, fa_sum8, fa_carry8, busy8, done8, cout8;
    logic [7:0] sum8;
    assign fa_sum8   = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fa_carry8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_carry(fa_carry8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
    );

    // 1-bit instance
    logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic fa_a1, fa_b1, fa_cin1, fa_sum1, fa_carry1, busy1, done1, sum1, cout1;
    assign fa_sum1   = fa_a1 ^ fa_b1 ^ fa_cin1;
    assign fa_carry1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin_in(cin1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_carry(fa_carry1),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [8:0] model_res = '0;   // {cout, sum} the 8-bit DUT should currently hold

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        @(posedge clk);
    endtask

    // Called at a negedge in RUN; returns at the negedge where done is seen (or on timeout).
    task automatic finish8(input logic [8:0] prev, output int nbusy, output bit seen,
                           output bit held, output int done_cyc);
        nbusy = 0; seen = 1'b0; held = 1'b1; done_cyc = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else begin
                if (busy8) nbusy++;
                if ({cout8, sum8} !== prev) held = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] exp_sum, input logic exp_cout,
                        input string tag, output int done_cyc);
        int nb;
        bit seen, held;
        launch8(a, b, c);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        check({tag, " fa_a"}, 32'(fa_a8), 32'(a[0]));
        check({tag, " fa_b"}, 32'(fa_b8), 32'(b[0]));
        check({tag, " fa_cin"}, 32'(fa_cin8), 32'(c));
        finish8(model_res, nb, seen, held, done_cyc);
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " busy_cycles"}, 32'(nb), 32'd8);
        check({tag, " result_held"}, 32'(held), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy8), 32'd0);
        check({tag, " sum"}, 32'(sum8), 32'(exp_sum));
        check({tag, " cout"}, 32'(cout8), 32'(exp_cout));
        model_res = {exp_cout, exp_sum};
        $display("%s: 0x%02h + 0x%02h + %0d -> sum 0x%02h cout %0d (expect 0x%02h %0d)",
                 tag, a, b, c, sum8, cout8, exp_sum, exp_cout);
    endtask

    initial begin
        vec_t vecs[7];
        int dc1, dc2, nb, dones;
        bit seen, held;
        logic [7:0] ra, rb;
        logic rc;
        logic [8:0] rexp;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[3] = '{a: 8'h10, b: 8'h20, cin: 1'b0, sum: 8'h30, cout: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h7F, cin: 1'b1, sum: 8'h00, cout: 1'b1};
        vecs[5] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
        vecs[6] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst busy8", 32'(busy8), 32'd0);
        check("rst done8", 32'(done8), 32'd0);
        check("rst sum8", 32'(sum8), 32'd0);
        check("rst cout8", 32'(cout8), 32'd0);
        check("rst fa8", 32'({fa_a8, fa_b8, fa_cin8}), 32'd0);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst sum1", 32'({cout1, sum1}), 32'd0);
        rst_n = 1'b1;

        // Table vectors
        foreach (vecs[i])
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, "vec", dc1);

        // Start held high through RUN with operand A changing
        launch8(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        a8 = 8'hAA;
        finish8(model_res, nb, seen, held, dc1);
        check("hold done_seen", 32'(seen), 32'd1);
        check("hold busy_cycles", 32'(nb), 32'd8);
        check("hold sum", 32'({cout8, sum8}), 32'h030);
        model_res = 9'h030;
        @(negedge clk);
        check("hold single_done", 32'(done8), 32'd0);
        check("hold idle_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        check("hold relaunch", 32'(busy8), 32'd1);
        start8 = 1'b0;
        finish8(model_res, nb, seen, held, dc1);
        check("relaunch done_seen", 32'(seen), 32'd1);
        check("relaunch sum", 32'({cout8, sum8}), 32'h0CA);
        model_res = 9'h0CA;
        $display("hold: 0x10+0x20 then held start 0xAA+0x20 -> sum 0x%02h cout %0d", sum8, cout8);

        // Reset in RUN cycle 4
        launch8(8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy8), 32'd0);
        check("abort done", 32'(done8), 32'd0);
        check("abort sum", 32'({cout8, sum8}), 32'd0);
        check("abort fa", 32'({fa_a8, fa_b8, fa_cin8}), 32'd0);
        model_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("abort no_done", 32'(dones), 32'd0);
        $display("abort: reset during RUN, outputs cleared, %0d done pulses", dones);
        run8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, "post_abort", dc1);

        // WIDTH=1 truth table
        for (int k = 0; k < 8; k++) begin
            int s;
            s = k[0] + k[1] + k[2];
            @(negedge clk);
            start1 = 1'b1; a1 = k[0]; b1 = k[1]; cin1 = k[2];
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            check("w1 busy", 32'(busy1), 32'd1);
            check("w1 early_done", 32'(done1), 32'd0);
            @(negedge clk);
            check("w1 done", 32'(done1), 32'd1);
            check("w1 sum", 32'(sum1), 32'(s & 1));
            check("w1 cout", 32'(cout1), 32'(s >> 1));
            $display("w1: %0d+%0d+%0d -> sum %0d cout %0d", k[0], k[1], k[2], sum1, cout1);
        end

        // Back-to-back: second start in first IDLE cycle after DONE
        run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "b2b_first", dc1);
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "b2b_second", dc2);
        check("b2b done_spacing", 32'(dc2 - dc1), 32'd10);

        // Randomised operations against arithmetic model
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + 9'(rc);
            run8(ra, rb, rc, rexp[7:0], rexp[8], "rand", dc1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
